// File: rtl/capture_sequencer_pkg.sv
// Shared constants and encodings for the capture sequencer: widths, channel
// offsets inside the packed sample word, and the FSM state and trigger mode enums.
package capture_pkg;

  localparam int DATA_W = 32;
  localparam int CH_W   = 12;
  localparam int LEN_W  = 16;
  localparam int DEC_W  = 8;
  localparam int TMO_W  = 24;

  localparam int CH1_LSB = 0;
  localparam int CH2_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    MODE_IMMEDIATE = 2'b00,
    MODE_RISING    = 2'b01,
    MODE_FALLING   = 2'b10,
    MODE_EITHER    = 2'b11
  } mode_e;

endpackage

// File: rtl/capture_sequencer_if.sv
// Sample path bundle: the source stream entering the sequencer, the decimated
// stream leaving it toward storage, and the storage-full indication.
interface capture_sequencer_if;
  import capture_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              store_complete;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, store_complete,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, store_complete,
    output out_valid, out_data
  );

endinterface

// File: rtl/capture_sequencer_trigger_detect.sv
// Level/slope trigger on the selected channel with a forced-trigger timeout.
// trig is a single-cycle strobe qualified by in_valid while armed.
module trigger_detect
  import capture_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             armed,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  ch1,
  input  logic [CH_W-1:0]  ch2,
  input  mode_e            mode,
  input  logic             chan,
  input  logic [CH_W-1:0]  level,
  input  logic [TMO_W-1:0] timeout,
  output logic             trig,
  output logic             timed_out
);

  logic [CH_W-1:0]  cur;
  logic [CH_W-1:0]  prev;
  logic             prev_valid;
  logic [TMO_W-1:0] tmo_cnt;
  logic             expired;
  logic             rise;
  logic             fall;
  logic             natural;
  logic             tmo_hit;

  // NOTE: every always_comb output is assigned on every path (defaults or full
  // case with default) so synthesis never infers a latch.
  always_comb begin
    cur  = chan ? ch2 : ch1;
    rise = prev_valid && (prev < level) && (cur >= level);
    fall = prev_valid && (prev >= level) && (cur < level);
    case (mode)
      MODE_IMMEDIATE: natural = 1'b1;
      MODE_RISING:    natural = rise;
      MODE_FALLING:   natural = fall;
      MODE_EITHER:    natural = rise || fall;
      default:        natural = 1'b0;
    endcase
    tmo_hit   = (timeout != '0) && (tmo_cnt == timeout);
    trig      = armed && in_valid && (natural || expired || tmo_hit);
    // A genuine edge in the same sample as expiry is reported as a real trigger.
    timed_out = trig && !natural;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      tmo_cnt    <= '0;
      expired    <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
      tmo_cnt    <= '0;
      expired    <= 1'b0;
    end else if (armed) begin
      if (in_valid) begin
        prev       <= cur;
        prev_valid <= 1'b1;
      end
      // Expiry is remembered so the forced trigger waits for the next sample.
      if (tmo_hit) begin
        tmo_cnt <= '0;
        expired <= 1'b1;
      end else if (timeout != '0) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Arm/trigger/capture sequencer: waits for a trigger, then forwards a programmed
// number of decimated samples to storage and reports sticky status to the host.
module capture_sequencer
  import capture_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  capture_sequencer_if.slave bus,
  input  logic               cfg_arm,
  input  logic               cfg_abort,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_chan,
  input  logic [CH_W-1:0]    cfg_level,
  input  logic [DEC_W-1:0]   cfg_decim,
  input  logic [LEN_W-1:0]   cfg_length,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               cfg_rearm,
  output logic [1:0]         status_state,
  output logic               status_triggered,
  output logic               status_timed_out,
  output logic [LEN_W-1:0]   status_count,
  output logic               done_pulse
);

  state_e            state;
  mode_e             mode_q;
  logic              chan_q;
  logic [CH_W-1:0]   level_q;
  logic [DEC_W-1:0]  decim_q;
  logic [LEN_W-1:0]  length_q;
  logic [TMO_W-1:0]  timeout_q;
  logic              rearm_q;
  logic [DEC_W-1:0]  phase_q;

  logic              arm_go;
  logic              rearm_go;
  logic              det_clear;
  logic              fwd;
  logic [LEN_W-1:0]  count_inc;
  logic              trig;
  logic              trig_timed_out;

  assign arm_go       = (state == ST_IDLE) && cfg_arm && !cfg_abort;
  assign rearm_go     = (state == ST_DONE) && rearm_q && !cfg_abort;
  assign det_clear    = arm_go || rearm_go;
  assign fwd          = bus.in_valid && (phase_q == '0);
  assign count_inc    = status_count + LEN_W'(1);
  assign status_state = state;

  trigger_detect u_trigger_detect (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (det_clear),
    .armed     (state == ST_ARMED),
    .in_valid  (bus.in_valid),
    .ch1       (bus.in_data[CH1_LSB +: CH_W]),
    .ch2       (bus.in_data[CH2_LSB +: CH_W]),
    .mode      (mode_q),
    .chan      (chan_q),
    .level     (level_q),
    .timeout   (timeout_q),
    .trig      (trig),
    .timed_out (trig_timed_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      mode_q           <= MODE_IMMEDIATE;
      chan_q           <= 1'b0;
      level_q          <= '0;
      decim_q          <= '0;
      length_q         <= '0;
      timeout_q        <= '0;
      rearm_q          <= 1'b0;
      phase_q          <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      status_triggered <= 1'b0;
      status_timed_out <= 1'b0;
      status_count     <= '0;
      done_pulse       <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      done_pulse    <= 1'b0;

      // Arm and re-arm share the same status/phase initialisation.
      if (det_clear) begin
        status_triggered <= 1'b0;
        status_timed_out <= 1'b0;
        status_count     <= '0;
        phase_q          <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (arm_go) begin
            mode_q    <= mode_e'(cfg_mode);
            chan_q    <= cfg_chan;
            level_q   <= cfg_level;
            decim_q   <= cfg_decim;
            length_q  <= cfg_length;
            timeout_q <= cfg_timeout;
            rearm_q   <= cfg_rearm;
            state     <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (cfg_abort) begin
            state <= ST_IDLE;
          end else if (trig) begin
            status_triggered <= 1'b1;
            status_timed_out <= trig_timed_out;
            if (length_q == '0) begin
              state      <= ST_DONE;
              done_pulse <= 1'b1;
            end else begin
              // The triggering sample is decimation phase 0 of the capture.
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.in_data;
              status_count  <= LEN_W'(1);
              phase_q       <= (decim_q == '0) ? '0 : DEC_W'(1);
              if (length_q == LEN_W'(1)) begin
                state      <= ST_DONE;
                done_pulse <= 1'b1;
              end else begin
                state <= ST_CAPTURE;
              end
            end
          end
        end

        ST_CAPTURE: begin
          if (cfg_abort) begin
            state <= ST_IDLE;
          end else begin
            if (bus.in_valid) begin
              phase_q <= (phase_q == decim_q) ? '0 : phase_q + DEC_W'(1);
            end
            if (fwd) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.in_data;
              status_count  <= count_inc;
            end
            if (bus.store_complete || (fwd && (count_inc == length_q))) begin
              state      <= ST_DONE;
              done_pulse <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= rearm_go ? ST_ARMED : ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomised bench for capture_sequencer: per capture, the input samples are
// recorded and the expected forwarded list is derived from the trigger rules.
module tb_capture_sequencer;
  import capture_pkg::*;

  typedef enum int {K_RAMP1, K_FALL2, K_RAND, K_LOW1} kind_e;

  typedef struct {
    logic [1:0]       mode;
    logic             chan;
    logic [CH_W-1:0]  level;
    logic [DEC_W-1:0] decim;
    logic [LEN_W-1:0] length;
    logic [TMO_W-1:0] timeout;
    logic             rearm;
    kind_e            kind;
    int               store_after;
  } scen_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  capture_sequencer_if bus();

  logic             cfg_arm = 1'b0;
  logic             cfg_abort = 1'b0;
  logic [1:0]       cfg_mode = '0;
  logic             cfg_chan = 1'b0;
  logic [CH_W-1:0]  cfg_level = '0;
  logic [DEC_W-1:0] cfg_decim = '0;
  logic [LEN_W-1:0] cfg_length = '0;
  logic [TMO_W-1:0] cfg_timeout = '0;
  logic             cfg_rearm = 1'b0;
  logic [1:0]       status_state;
  logic             status_triggered;
  logic             status_timed_out;
  logic [LEN_W-1:0] status_count;
  logic             done_pulse;

  capture_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .cfg_arm          (cfg_arm),
    .cfg_abort        (cfg_abort),
    .cfg_mode         (cfg_mode),
    .cfg_chan         (cfg_chan),
    .cfg_level        (cfg_level),
    .cfg_decim        (cfg_decim),
    .cfg_length       (cfg_length),
    .cfg_timeout      (cfg_timeout),
    .cfg_rearm        (cfg_rearm),
    .status_state     (status_state),
    .status_triggered (status_triggered),
    .status_timed_out (status_timed_out),
    .status_count     (status_count),
    .done_pulse       (done_pulse)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] last_got[$];
  logic        last_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] make_sample(input kind_e k, input int n);
    logic [11:0] c1;
    logic [11:0] c2;
    c1 = 12'($urandom);
    c2 = 12'($urandom);
    case (k)
      K_RAMP1: c1 = 12'(n);
      K_FALL2: c2 = 12'(32'h900 - 32'(16 * n));
      K_LOW1:  c1 = 12'($urandom_range(0, 32'h7FF));
      default: ;
    endcase
    return {4'h0, c2, 4'h0, c1};
  endfunction

  function automatic scen_t mk(input logic [1:0] mode, input logic chan, input int level,
                               input int decim, input int length, input int timeout,
                               input logic rearm, input kind_e kind, input int store_after);
    scen_t s;
    s.mode = mode; s.chan = chan; s.level = CH_W'(level); s.decim = DEC_W'(decim);
    s.length = LEN_W'(length); s.timeout = TMO_W'(timeout); s.rearm = rearm;
    s.kind = kind; s.store_after = store_after;
    return s;
  endfunction

  task automatic pulse_abort();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.store_complete = 1'b0;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
  endtask

  // One arm-to-done capture; the expected output is computed from the recorded
  // samples after the run using the trigger, decimation and stop rules.
  task automatic run(input string name, input scen_t s);
    logic [31:0] samp_d[$];
    int          samp_k[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int          n = 0;
    int          done_cnt = 0;
    int          done_k = -1;
    int          store_k = -1;
    logic [LEN_W-1:0] cnt_done = '0;
    logic        trg_done = 1'b0;
    logic        tmo_done = 1'b0;
    logic [1:0]  st_after = 2'b00;
    logic        trg_after = 1'b0;
    logic [LEN_W-1:0] cnt_after = '0;
    int          trig_i = -1;
    logic        exp_tmo = 1'b0;
    logic        prev_valid = 1'b0;
    logic [11:0] prev = '0;
    logic [11:0] cur;
    logic        rise, fall, nat, forced;
    logic [31:0] d;

    @(negedge clk);
    cfg_mode = s.mode; cfg_chan = s.chan; cfg_level = s.level; cfg_decim = s.decim;
    cfg_length = s.length; cfg_timeout = s.timeout; cfg_rearm = s.rearm;
    cfg_arm = 1'b1;
    bus.in_valid = 1'b0;
    bus.store_complete = 1'b0;
    @(negedge clk);
    cfg_arm = 1'b0;

    for (int k = 0; k < 600; k++) begin
      if (k == 0) begin
        check({name, " armed state"}, 32'(status_state), 32'(ST_ARMED));
        check({name, " armed count"}, 32'(status_count), 0);
        check({name, " armed trig"}, 32'(status_triggered), 0);
      end
      if (bus.out_valid) got.push_back(bus.out_data);
      if (done_k >= 0 && k == done_k + 1) begin
        st_after = status_state; trg_after = status_triggered; cnt_after = status_count;
      end
      if (done_pulse) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k; cnt_done = status_count; trg_done = status_triggered;
          tmo_done = status_timed_out;
        end
      end
      if (done_k >= 0 && k == done_k + 1) break;

      // Shadowed configuration: changes after arm must be ignored.
      cfg_mode = 2'($urandom); cfg_chan = 1'($urandom); cfg_level = CH_W'($urandom);
      cfg_decim = DEC_W'($urandom); cfg_length = LEN_W'($urandom);
      cfg_timeout = TMO_W'($urandom); cfg_rearm = 1'($urandom);

      if (s.store_after > 0 && got.size() == s.store_after && store_k < 0) begin
        bus.store_complete = 1'b1;
        store_k = k;
      end else begin
        bus.store_complete = 1'b0;
      end

      bus.in_valid = ($urandom_range(0, 3) != 0);
      if (bus.in_valid) begin
        d = make_sample(s.kind, n);
        n++;
        samp_d.push_back(d);
        samp_k.push_back(k);
        bus.in_data = d;
      end else begin
        bus.in_data = $urandom;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.store_complete = 1'b0;

    foreach (samp_d[i]) begin
      d = samp_d[i];
      cur = s.chan ? d[27:16] : d[11:0];
      rise = prev_valid && (prev < s.level) && (cur >= s.level);
      fall = prev_valid && (prev >= s.level) && (cur < s.level);
      case (s.mode)
        2'b00:   nat = 1'b1;
        2'b01:   nat = rise;
        2'b10:   nat = fall;
        default: nat = rise || fall;
      endcase
      forced = (s.timeout != 0) && (samp_k[i] >= int'(s.timeout));
      if (nat || forced) begin
        trig_i = i;
        exp_tmo = !nat;
        break;
      end
      prev = cur;
      prev_valid = 1'b1;
    end
    if (trig_i >= 0) begin
      for (int j = 0; j < int'(s.length); j++) begin
        int idx;
        idx = trig_i + j * (int'(s.decim) + 1);
        if (idx >= samp_d.size()) break;
        if (store_k >= 0 && samp_k[idx] > store_k) break;
        exp_q.push_back(samp_d[idx]);
      end
    end

    check({name, " trigger seen"}, 32'(trig_i >= 0), 1);
    check({name, " done count"}, 32'(done_cnt), 1);
    check({name, " n out"}, 32'(got.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) check($sformatf("%s out[%0d]", name, i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, exp_q[i]);
    check({name, " count at done"}, 32'(cnt_done), 32'(exp_q.size()));
    check({name, " triggered"}, 32'(trg_done), 1);
    check({name, " timed_out"}, 32'(tmo_done), 32'(exp_tmo));
    check({name, " state after"}, 32'(st_after), s.rearm ? 32'(ST_ARMED) : 32'(ST_IDLE));
    if (s.rearm) begin
      check({name, " rearm count"}, 32'(cnt_after), 0);
      check({name, " rearm trig"}, 32'(trg_after), 0);
    end
    last_got = got;
    last_tmo = tmo_done;
    pulse_abort();
  endtask

  initial begin
    int seen;
    logic [31:0] w;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.store_complete = 1'b0;
    #12;
    check("reset state", 32'(status_state), 0);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset out_data", bus.out_data, 0);
    check("reset count", 32'(status_count), 0);
    check("reset triggered", 32'(status_triggered), 0);
    check("reset timed_out", 32'(status_timed_out), 0);
    check("reset done", 32'(done_pulse), 0);
    reset_n = 1'b1;

    run("immediate", mk(2'b00, 1'b0, 0, 0, 4, 0, 1'b0, K_RAMP1, 0));
    for (int j = 0; j < 4; j++) begin
      w = (j < last_got.size()) ? last_got[j] : 32'hFFFF_FFFF;
      check($sformatf("immediate ch1[%0d]", j), 32'(w[11:0]), 32'(j));
    end

    run("rising", mk(2'b01, 1'b0, 100, 0, 3, 0, 1'b0, K_RAMP1, 0));
    w = (last_got.size() > 0) ? last_got[0] : 32'hFFFF_FFFF;
    check("rising first ch1", 32'(w[11:0]), 100);

    run("falling", mk(2'b10, 1'b1, 12'h800, 3, 3, 0, 1'b0, K_FALL2, 0));
    for (int j = 0; j < 3; j++) begin
      w = (j < last_got.size()) ? last_got[j] : 32'hFFFF_FFFF;
      check($sformatf("falling ch2[%0d]", j), 32'(w[27:16]), 32'h7F0 - 32'(j * 64));
    end

    run("timeout", mk(2'b01, 1'b0, 12'hF00, 1, 3, 50, 1'b0, K_LOW1, 0));
    check("timeout flag", 32'(last_tmo), 1);

    run("store stop", mk(2'b00, 1'b0, 0, 0, 10, 0, 1'b0, K_RAMP1, 2));
    run("length zero", mk(2'b00, 1'b0, 0, 0, 0, 0, 1'b0, K_RAND, 0));
    run("rearm", mk(2'b00, 1'b0, 0, 1, 2, 0, 1'b1, K_RAND, 0));

    for (int r = 0; r < 6; r++) begin
      run($sformatf("random%0d", r),
          mk(2'($urandom), 1'($urandom), int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 6)), int'($urandom_range(20, 80)), 1'b0, K_RAND, 0));
    end

    // Abort coincident with arm in IDLE: abort wins.
    @(negedge clk);
    cfg_mode = 2'b00; cfg_length = 16'd20; cfg_decim = '0; cfg_timeout = '0; cfg_rearm = 1'b0;
    cfg_arm = 1'b1; cfg_abort = 1'b1;
    @(negedge clk);
    cfg_arm = 1'b0; cfg_abort = 1'b0;
    check("idle abort+arm state", 32'(status_state), 0);

    // Abort mid-capture coincident with arm.
    cfg_arm = 1'b1;
    @(negedge clk);
    cfg_arm = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && seen < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = make_sample(K_RAND, i);
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort reached capture", 32'(seen), 2);
    cfg_abort = 1'b1; cfg_arm = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0; cfg_arm = 1'b0;
    check("abort state", 32'(status_state), 0);
    check("abort out_valid", 32'(bus.out_valid), 0);
    check("abort done", 32'(done_pulse), 0);
    @(negedge clk);
    check("abort stays idle", 32'(status_state), 0);
    check("abort sticky trig", 32'(status_triggered), 1);
    check("abort no late done", 32'(done_pulse), 0);

    // Async reset in the middle of a capture.
    cfg_arm = 1'b1;
    @(negedge clk);
    cfg_arm = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = make_sample(K_RAND, i);
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("reset mid capture reached", 32'(seen), 1);
    #1 reset_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(bus.out_valid), 0);
    check("async reset state", 32'(status_state), 0);
    check("async reset count", 32'(status_count), 0);
    check("async reset out_data", bus.out_data, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post reset idle", 32'(status_state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Sits between the sample source (packed two-channel 12-bit stream) and the sample-storage bridge input. It arms on a host command and waits for a level/slope trigger on a selected channel, or a timeout. It then forwards a programmed number of decimated samples to storage and reports status back to the host-visible PIO registers.

Parameters:
DATA_W, 32, sample word width; ch1 = in_data[11:0], ch2 = in_data[27:16]
CH_W, 12, channel sample width
LEN_W, 16, capture length counter width
DEC_W, 8, decimation counter width
TMO_W, 24, trigger timeout counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  sample strobe from source
in_data  in  DATA_W  packed sample {4'h0,ch2,4'h0,ch1}
cfg_arm  in  1  single-cycle arm request
cfg_abort  in  1  single-cycle abort request
cfg_mode  in  2  00 immediate, 01 rising, 10 falling, 11 either edge
cfg_chan  in  1  0 = ch1, 1 = ch2
cfg_level  in  CH_W  trigger threshold, unsigned
cfg_decim  in  DEC_W  forward one of every cfg_decim+1 samples
cfg_length  in  LEN_W  samples to forward per capture
cfg_timeout  in  TMO_W  clk cycles in ARMED before forced trigger; 0 disables
cfg_rearm  in  1  return to ARMED instead of IDLE after capture
store_complete  in  1  storage full indication
out_valid  out  1  sample strobe to storage
out_data  out  DATA_W  forwarded sample
status_state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
status_triggered  out  1  sticky: trigger seen since last arm
status_timed_out  out  1  sticky: last trigger was forced by timeout
status_count  out  LEN_W  samples forwarded in current/last capture
done_pulse  out  1  one-cycle capture-finished strobe

Behaviour:
- Reset: state IDLE; all outputs 0; all counters and the prev-sample register 0.
- Reset is asynchronous and active-low. Assertion mid-capture drops out_valid immediately, with no partial flush.
- cfg_* are latched into shadow registers on accepted cfg_arm. Changes while not IDLE have no effect until the next arm.
- IDLE:
  - cfg_arm goes to ARMED.
  - On arm: clear status_triggered, status_timed_out, status_count, the prev-valid flag, and the decimation and timeout counters.
- ARMED:
  - Nothing is forwarded.
  - Each in_valid compares the selected channel (cur) with prev.
  - Rising: prev_valid && prev < level && cur >= level.
  - Falling: prev_valid && prev >= level && cur < level.
  - Immediate (mode 00): triggers on the first in_valid after arm.
  - prev is updated on every in_valid.
  - Timeout counter increments every clk. When it reaches cfg_timeout (nonzero), force trigger on the next in_valid and set status_timed_out.
  - On trigger, go to CAPTURE and set status_triggered. The triggering sample is the first forwarded sample (decimation phase 0).
- CAPTURE:
  - On in_valid with decimation phase 0: out_valid = 1 and out_data = in_data, registered (1 clk latency); status_count++.
  - Phase counts 0..cfg_decim, then wraps to 0.
  - Exits to DONE when status_count reaches cfg_length (after the last forwarded sample) or when store_complete = 1 (early stop; a sample in the same cycle is still forwarded).
  - cfg_length = 0: enter DONE on the cycle after trigger with zero samples forwarded.
- DONE: one cycle. done_pulse = 1. Next state is ARMED (re-init as on arm, config retained) if cfg_rearm, else IDLE.
- cfg_abort in any non-IDLE state goes to IDLE next cycle with no done_pulse; sticky status is retained.
- Abort and arm in the same cycle: abort wins.
- Arm while not IDLE is ignored.
- Counter widths saturate by construction: status_count never exceeds cfg_length. Decim/timeout counters compare with equality and reset on match.

Decomposition:
- Package capture_pkg: state encoding (IDLE/ARMED/CAPTURE/DONE), mode encoding, channel bit offsets (0, 16).
- One sub-module, trigger_detect: channel select, prev register, slope comparators, and the timeout counter. It outputs a single-cycle trig and a timed_out flag.
- The FSM, decimator, length counter and output register stay in the top.

Test Plan:
- Immediate, decim=0, length=4, ramp ch1 = 0,1,2,…: out_data ch1 = 0,1,2,3 on 4 consecutive out_valid; done_pulse once; state returns to 00; status_count = 4.
- Rising, chan=ch1, level=100, ch1 ramp +1: first out_data ch1 = 100 (prev 99); status_triggered = 1; timed_out = 0.
- Falling, chan=ch2, level=0x800, ch2 descending by 16 from 0x900: trigger on first sample < 0x800 (0x7F0); decim=3, length=3: forwarded ch2 = 0x7F0, 0x7B0, 0x770.
- Rising, level above the signal range, timeout=50: forced trigger on the first in_valid after 50 clk; status_timed_out = 1; length samples forwarded.
- store_complete asserted after the 2nd forwarded sample with length=10: DONE with status_count = 2 (or 3 if coincident with a sample); done_pulse once.
- Abort mid-CAPTURE coincident with arm: IDLE next cycle, no done_pulse, out_valid = 0. rearm=1 run: after done_pulse, state = ARMED with status cleared. Async reset mid-capture: outputs 0 immediately.
